alu_cmd_sequencer: RTL and testbench

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_cmd_sequencer.sv | 141 ++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Queues ALU commands in a small FIFO and feeds the head entry to an external
//   combinational ALU. It captures the ALU result into a registered output
//   stage that uses a valid/ready handshake.
//
//   Parameter DEPTH : number of FIFO entries (power of two, 2..16).
//   clk, rst_n      : rising-edge clock, asynchronous active-low reset.
//   in_*            : command input handshake {in_sel, in_a, in_b}.
//   alu_a/b/sel     : head-of-FIFO operands to the ALU (0 when the FIFO is empty).
//   alu_y/carry     : ALU result inputs.
//   out_*           : registered result handshake plus the op code that produced it.
//   Optional macro ALU_ZERO_FLAG_EN adds out_zero, which is registered
//   alongside out_y.
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_sel,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [3:0] alu_y,
  input  logic       alu_carry,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_y,
  output logic       out_carry,
  output logic [2:0] out_sel
`ifdef ALU_ZERO_FLAG_EN
  ,
  output logic       out_zero
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [10:0]   mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          en_q;
  logic          out_valid_q, out_valid_d;
  logic [3:0]    out_y_q, out_y_d;
  logic          out_carry_q, out_carry_d;
  logic [2:0]    out_sel_q, out_sel_d;
  logic          push, issue, empty;
  logic [10:0]   head;

  // en_q holds in_ready low during reset and releases it on the first edge
  // after reset. in_ready therefore comes only from registered state.
  assign empty    = (count_q == '0);
  assign in_ready = en_q && (count_q < FULL_C);
  assign push     = in_valid && in_ready;
  assign issue    = !empty && (!out_valid_q || out_ready);
  assign head     = mem_q[rptr_q];

  always_comb begin
    alu_sel = '0;
    alu_a   = '0;
    alu_b   = '0;
    if (!empty) begin
      alu_sel = head[10:8];
      alu_a   = head[7:4];
      alu_b   = head[3:0];
    end
  end

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_carry_d = out_carry_q;
    out_sel_d   = out_sel_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (issue) begin
      rptr_d      = rptr_q + 1'b1;
      out_valid_d = 1'b1;
      out_y_d     = alu_y;
      out_carry_d = alu_carry;
      out_sel_d   = alu_sel;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    case ({push, issue})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q        <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_carry_q <= 1'b0;
      out_sel_q   <= '0;
    end else begin
      en_q        <= 1'b1;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_carry_q <= out_carry_d;
      out_sel_q   <= out_sel_d;
    end
  end

  // Storage needs no reset: count_q gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {in_sel, in_a, in_b};
  end

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_carry = out_carry_q;
  assign out_sel   = out_sel_q;

`ifdef ALU_ZERO_FLAG_EN
  logic out_zero_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     out_zero_q <= 1'b0;
    else if (issue) out_zero_q <= (alu_y == '0);
  end
  assign out_zero = out_zero_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_sel;
  logic [3:0] in_a, in_b;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_sel;
  logic [3:0] alu_y;
  logic       alu_carry;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_y;
  logic       out_carry;
  logic [2:0] out_sel;
`ifdef ALU_ZERO_FLAG_EN
  logic       out_zero;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_a      (in_a),
    .in_b      (in_b),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_y     (alu_y),
    .alu_carry (alu_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_carry (out_carry),
    .out_sel   (out_sel)
`ifdef ALU_ZERO_FLAG_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  // Reference ALU: returns {sel, carry, y}.
  // Op codes: add, sub (carry = borrow), and, or, xor, nand, nor, xnor.
  function automatic logic [7:0] alu_f(input logic [2:0] s, input logic [3:0] a,
                                       input logic [3:0] b);
    logic [4:0] r;
    case (s)
      3'd0:    r = {1'b0, a} + {1'b0, b};
      3'd1:    r = {(a < b), a - b};
      3'd2:    r = {1'b0, a & b};
      3'd3:    r = {1'b0, a | b};
      3'd4:    r = {1'b0, a ^ b};
      3'd5:    r = {1'b0, ~(a & b)};
      3'd6:    r = {1'b0, ~(a | b)};
      default: r = {1'b0, ~(a ^ b)};
    endcase
    return {s, r};
  endfunction

  always_comb begin
    {alu_carry, alu_y} = alu_f(alu_sel, alu_a, alu_b) ;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [3:0] a,
                       input logic [3:0] b);
    in_valid = v;
    in_sel   = s;
    in_a     = a;
    in_b     = b;
  endtask

  // Single command with the output free. The bench drives it at a negedge,
  // pushes it on the next edge and expects the result one edge later.
  task automatic one_cmd(input string tag, input logic [2:0] s, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] ey, input logic ec);
    out_ready = 1'b1;
    drive(1'b1, s, a, b);
    @(negedge clk);
    drive(1'b0, 3'd0, 4'd0, 4'd0);
    check({tag, "_lat_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_head"}, {21'd0, alu_sel, alu_a, alu_b}, {21'd0, s, a, b});
    @(negedge clk);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_res"}, {24'd0, out_sel, out_carry, out_y}, {24'd0, s, ec, ey});
    @(negedge clk);
    check({tag, "_drain"}, {31'd0, out_valid}, 32'd0);
  endtask

  logic [2:0] fs [5] = '{3'd0, 3'd1, 3'd3, 3'd5, 3'd4};
  logic [3:0] fa [5] = '{4'h7, 4'h8, 4'h4, 4'hF, 4'h6};
  logic [3:0] fb [5] = '{4'h8, 4'h3, 4'h2, 4'hE, 4'h4};
  logic [3:0] fy [5] = '{4'hF, 4'h5, 4'h6, 4'h1, 4'h2};

  initial begin
    logic [7:0] sb[$];
    logic [7:0] exp8;
    int unsigned sent, got, cyc;

    rst_n = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 3'd0, 4'd0, 4'd0);
    #2;
    check("rst_outs", {22'd0, out_valid, in_ready, out_sel, out_carry, out_y}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_ready_low", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("rst_ready_up", {31'd0, in_ready}, 32'd1);

    one_cmd("add98", 3'd0, 4'h9, 4'h8, 4'h1, 1'b1);
    one_cmd("sub35", 3'd1, 4'h3, 4'h5, 4'hE, 1'b1);
    one_cmd("andCA", 3'd2, 4'hC, 4'hA, 4'h8, 1'b0);
    one_cmd("xnor53", 3'd7, 4'h5, 4'h3, 4'h9, 1'b0);
`ifdef ALU_ZERO_FLAG_EN
    out_ready = 1'b1;
    drive(1'b1, 3'd4, 4'hA, 4'hA);
    @(negedge clk);
    drive(1'b0, 3'd0, 4'd0, 4'd0);
    @(negedge clk);
    check("zero_y", {28'd0, out_y}, 32'd0);
    check("zero_flag", {31'd0, out_zero}, 32'd1);
    @(negedge clk);
    one_cmd("add11", 3'd0, 4'h1, 4'h1, 4'h2, 1'b0);
    check("zero_clear", {31'd0, out_zero}, 32'd0);
`endif

    // Fill: one result in the output register plus four queued entries.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, fs[i], fa[i], fb[i]);
      @(negedge clk);
    end
    drive(1'b1, 3'd0, 4'h1, 4'h1);  // offered while full; must not be taken
    check("full_ready", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      check("hold_out", {23'd0, out_valid, out_sel, out_carry, out_y},
            {23'd0, 1'b1, fs[0], 1'b0, fy[0]});
      check("hold_head", {21'd0, alu_sel, alu_a, alu_b}, {21'd0, fs[1], fa[1], fb[1]});
      check("hold_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    drive(1'b0, 3'd0, 4'd0, 4'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("drain_res", {23'd0, out_valid, out_sel, out_carry, out_y},
            {23'd0, 1'b1, fs[i], 1'b0, fy[i]});
      @(negedge clk);
    end
    check("drain_empty", {31'd0, out_valid}, 32'd0);

    // Random stream against the scoreboard.
    sent = 0; got = 0; cyc = 0;
    while (got < 20 && cyc < 1000) begin
      drive(sent < 20, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)));
      out_ready = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) begin
        sb.push_back(alu_f(in_sel, in_a, in_b));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("stream_extra", 32'd1, 32'd0);
        end else begin
          exp8 = sb.pop_front();
          check("stream_res", {24'd0, out_sel, out_carry, out_y}, {24'd0, exp8});
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    drive(1'b0, 3'd0, 4'd0, 4'd0);
    check("stream_count", got, 32'd20);
    @(negedge clk);
    check("stream_idle", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset with three entries queued and a result held.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd0, 4'(i), 4'h1);
      @(negedge clk);
    end
    drive(1'b0, 3'd0, 4'd0, 4'd0);
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    check("pre_rst_head", {28'd0, alu_a}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_outs", {22'd0, out_valid, in_ready, out_sel, out_carry, out_y}, 32'd0);
    check("arst_head", {21'd0, alu_sel, alu_a, alu_b}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_empty", {20'd0, out_valid, alu_sel, alu_a, alu_b}, 32'd0);
    one_cmd("post_sub92", 3'd1, 4'h9, 4'h2, 4'h7, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
